sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_param.sv | 142 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the parameterised synchronous FIFO, and a ceil(log2) helper
// that the top level uses to validate its address width.
package fifo_pkg;

   localparam int DEF_BITS       = 12;
   localparam int DEF_WORD_DEPTH = 8;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_AF_LEVEL   = 6;
   localparam int DEF_AE_LEVEL   = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: 1-write/1-read register array, write on the rising edge, asynchronous read.
// There is no reset; the controller's pointers decide which words are valid.
module fifo_mem #(
   parameter int BITS  = 12,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [BITS-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr,
   output logic [BITS-1:0] o_rdata
);

   logic [BITS-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered status flags, overflow/underflow pulses and
// selectable output mode: registered read data (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int BITS       = DEF_BITS,
   parameter int word_depth = DEF_WORD_DEPTH,
   parameter int addr_width = DEF_ADDR_WIDTH,
   parameter int AF_LEVEL   = DEF_AF_LEVEL,
   parameter int AE_LEVEL   = DEF_AE_LEVEL,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write,
   input  logic                  read,
   input  logic [BITS-1:0]       data_in,
   output logic [BITS-1:0]       data_out,
   output logic                  ready,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [addr_width:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   if (addr_width != clog2(word_depth)) begin : g_bad_cfg
      $error("sync_fifo_param: addr_width must equal log2(word_depth)");
   end

   localparam logic [addr_width-1:0] LAST_PTR  = addr_width'(word_depth - 1);
   localparam logic [addr_width:0]   DEPTH_CNT = (addr_width + 1)'(word_depth);
   localparam logic [31:0]           AF_U      = 32'(AF_LEVEL);
   localparam logic [31:0]           AE_U      = 32'(AE_LEVEL);
   localparam bit                    AF_EN     = (AF_LEVEL <= word_depth);
   localparam bit                    AF_RST    = (AF_LEVEL == 0);

   logic [addr_width-1:0] r_wr_ptr;
   logic [addr_width-1:0] r_rd_ptr;
   logic [addr_width:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [addr_width:0]   w_cnt_nxt;
   logic [BITS-1:0]       w_head;

   // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
   assign w_rd_acc = read & ~r_empty;
   assign w_wr_acc = write & (~r_full | w_rd_acc);

   always_comb begin
      w_cnt_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_cnt_nxt = r_count + 1'b1;
         2'b01:   w_cnt_nxt = r_count - 1'b1;
         default: w_cnt_nxt = r_count;
      endcase
   end

   fifo_mem #(
      .BITS  (BITS),
      .DEPTH (word_depth),
      .AW    (addr_width)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Flags are computed from the next count so they update on the same edge as count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= AF_RST;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         r_count        <= w_cnt_nxt;
         r_full         <= (w_cnt_nxt == DEPTH_CNT);
         r_empty        <= (w_cnt_nxt == '0);
         r_almost_full  <= AF_EN && (32'(w_cnt_nxt) >= AF_U);
         r_almost_empty <= (32'(w_cnt_nxt) <= AE_U);
         r_overflow     <= write & ~w_wr_acc;
         r_underflow    <= read & ~w_rd_acc;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Gate with empty so a stale head word is never presented, including during reset.
      assign data_out = r_empty ? '0 : w_head;
      assign ready    = ~r_empty;
   end else begin : g_std
      logic [BITS-1:0] r_data_out;
      logic            r_ready;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_data_out <= '0;
            r_ready    <= 1'b0;
         end else begin
            r_ready <= w_rd_acc;
            if (w_rd_acc) begin
               r_data_out <= w_head;
            end
         end
      end

      assign data_out = r_data_out;
      assign ready    = r_ready;
   end

   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance.
module tb_sync_fifo_param;

   logic        clk;
   logic        rst, wr, rd;
   logic [11:0] din, dout;
   logic        rdy, full, empty, af, ae, ovf, udf;
   logic [3:0]  cnt;

   logic        rst_f, wr_f, rd_f;
   logic [11:0] din_f, dout_f;
   logic        rdy_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
   logic [3:0]  cnt_f;

   int n_chk;
   int n_err;

   sync_fifo_param u_std (
      .clk(clk), .rst(rst), .write(wr), .read(rd), .data_in(din),
      .data_out(dout), .ready(rdy), .full(full), .empty(empty),
      .almost_full(af), .almost_empty(ae), .count(cnt),
      .overflow(ovf), .underflow(udf)
   );

   sync_fifo_param #(.FWFT(1)) u_fwft (
      .clk(clk), .rst(rst_f), .write(wr_f), .read(rd_f), .data_in(din_f),
      .data_out(dout_f), .ready(rdy_f), .full(full_f), .empty(empty_f),
      .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
      .overflow(ovf_f), .underflow(udf_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
      rst_f = 1'b1; wr_f = 1'b0; rd_f = 1'b0; din_f = '0;
      #1;
      check("rst_cnt",   32'(cnt),   32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full",  32'(full),  32'd0);
      check("rst_ae",    32'(ae),    32'd1);
      check("rst_af",    32'(af),    32'd0);
      check("rst_rdy",   32'(rdy),   32'd0);
      check("rst_dout",  32'(dout),  32'd0);
      check("rst_ovf",   32'(ovf),   32'd0);
      check("rst_udf",   32'(udf),   32'd0);
      check("rst_f_rdy", 32'(rdy_f), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      rst_f = 1'b0;

      // fill
      for (int i = 0; i < 8; i++) begin
         din = (i == 0) ? 12'h0E0 : 12'(i);
         wr  = 1'b1;
         tick();
         check("fill_cnt",  32'(cnt),  32'(i + 1));
         check("fill_af",   32'(af),   32'((i + 1) >= 6));
         check("fill_ae",   32'(ae),   32'((i + 1) <= 2));
         check("fill_full", 32'(full), 32'(i == 7));
         check("fill_ovf",  32'(ovf),  32'd0);
      end
      wr = 1'b0;

      // overflow
      din = 12'h008;
      wr  = 1'b1;
      tick();
      wr = 1'b0;
      check("ovf_pulse", 32'(ovf),  32'd1);
      check("ovf_cnt",   32'(cnt),  32'd8);
      check("ovf_full",  32'(full), 32'd1);
      tick();
      check("ovf_clear", 32'(ovf),  32'd0);
      check("ovf_cnt2",  32'(cnt),  32'd8);

      // drain, then one read too many
      rd = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("drain_dout", 32'(dout), (i == 0) ? 32'h0E0 : 32'(i));
         check("drain_rdy",  32'(rdy),  32'd1);
         check("drain_cnt",  32'(cnt),  32'(7 - i));
      end
      check("drain_empty", 32'(empty), 32'd1);
      tick();
      check("udf_pulse", 32'(udf),  32'd1);
      check("udf_dout",  32'(dout), 32'h007);
      check("udf_rdy",   32'(rdy),  32'd0);
      rd = 1'b0;
      tick();
      check("udf_clear", 32'(udf),  32'd0);
      check("udf_hold",  32'(dout), 32'h007);

      // refill with 0x001..0x008, then 14 simultaneous write+read at full
      wr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = 12'(i + 1);
         tick();
      end
      check("refill_full", 32'(full), 32'd1);
      rd = 1'b1;
      for (int i = 0; i < 14; i++) begin
         din = 12'(16 + i);
         tick();
         check("sim_cnt",  32'(cnt),  32'd8);
         check("sim_ovf",  32'(ovf),  32'd0);
         check("sim_full", 32'(full), 32'd1);
         check("sim_rdy",  32'(rdy),  32'd1);
         check("sim_dout", 32'(dout), (i < 8) ? 32'(i + 1) : 32'(16 + i - 8));
      end
      wr = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         check("wrap_dout", 32'(dout), 32'(22 + j));
      end
      rd = 1'b0;
      tick();
      check("wrap_empty", 32'(empty), 32'd1);

      // reset mid-stream with five words stored
      wr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = 12'(48 + i);
         tick();
      end
      wr = 1'b0;
      check("mid_cnt", 32'(cnt), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_cnt",   32'(cnt),   32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_ae",    32'(ae),    32'd1);
      check("mid_rst_dout",  32'(dout),  32'd0);
      check("mid_rst_rdy",   32'(rdy),   32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_empty", 32'(empty), 32'd1);
      din = 12'h0AA;
      wr  = 1'b1;
      tick();
      wr = 1'b0;
      check("post_rst_cnt", 32'(cnt), 32'd1);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("post_rst_dout",  32'(dout),  32'h0AA);
      check("post_rst_rdy",   32'(rdy),   32'd1);
      check("post_rst_empty2", 32'(empty), 32'd1);
      tick();
      check("post_rst_rdy0", 32'(rdy),  32'd0);
      check("post_rst_hold", 32'(dout), 32'h0AA);

      // write and read together while empty: write wins, read underflows
      din = 12'h055;
      wr  = 1'b1;
      rd  = 1'b1;
      tick();
      wr = 1'b0;
      rd = 1'b0;
      check("ewr_udf",   32'(udf),   32'd1);
      check("ewr_cnt",   32'(cnt),   32'd1);
      check("ewr_empty", 32'(empty), 32'd0);
      check("ewr_rdy",   32'(rdy),   32'd0);
      tick();
      check("ewr_udf0", 32'(udf), 32'd0);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("ewr_dout", 32'(dout), 32'h055);

      // first-word-fall-through instance
      check("fw_empty0", 32'(empty_f), 32'd1);
      din_f = 12'h0AB;
      wr_f  = 1'b1;
      tick();
      wr_f = 1'b0;
      check("fw_rdy",  32'(rdy_f),  32'd1);
      check("fw_dout", 32'(dout_f), 32'h0AB);
      check("fw_cnt",  32'(cnt_f),  32'd1);
      rd_f = 1'b1;
      tick();
      rd_f = 1'b0;
      check("fw_empty", 32'(empty_f), 32'd1);
      check("fw_rdy0",  32'(rdy_f),   32'd0);
      wr_f  = 1'b1;
      din_f = 12'h0B1;
      tick();
      check("fw_head1", 32'(dout_f), 32'h0B1);
      din_f = 12'h0B2;
      tick();
      wr_f = 1'b0;
      check("fw_head1b", 32'(dout_f), 32'h0B1);
      rd_f = 1'b1;
      tick();
      rd_f = 1'b0;
      check("fw_head2", 32'(dout_f), 32'h0B2);
      check("fw_cnt2",  32'(cnt_f),  32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
